instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Instruction source for SimpleCPU: stores a short program and drives the CPU's 8-bit `instruction` input, one instruction per slot.
- Instruction format: [7:4] opcode, [3:0] operand. 4'h0 = ADD, 4'h1 = SUB, 4'hF = HALT; HALT is consumed here and never issued.
- Host loads the program through a write port, pulses `start`, and the block steps through memory until HALT, end of memory, or `stop`.

Parameters:
- ADDR_W, 4, program memory address width; depth = 2**ADDR_W.
- HOLD_CYCLES, 3, clock cycles each issued instruction is held on `instruction`; legal range >= 1.
- IDLE_INSTR, 8'h00, value driven on `instruction` when nothing is issued (ADD 0 = no-op).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- prog_we  input  1  program write strobe.
- prog_addr  input  ADDR_W  program write address.
- prog_data  input  8  program write data.
- start  input  1  begin execution at address 0; single-cycle pulse.
- stop  input  1  abort execution; single-cycle pulse.
- instruction  output  8  instruction to SimpleCPU; registered.
- instr_valid  output  1  high for the first cycle of each new instruction.
- pc  output  ADDR_W  address of the instruction currently presented.
- busy  output  1  high in RUN.
- done  output  1  high in DONE; level, not pulse.

Behaviour:
- Reset (async): state=IDLE, instruction=IDLE_INSTR, instr_valid=0, pc=0, busy=0, done=0, hold counter=0. Program memory is not cleared; contents survive reset.
- Memory write: when prog_we=1 and state!=RUN, mem[prog_addr] <= prog_data at the edge. Writes during RUN are ignored. A write and a fetch in the same cycle are not possible.
- States: IDLE, RUN, DONE. `busy` = (state==RUN); `done` = (state==DONE).
- IDLE or DONE, start=1 at edge:
  - mem[0] != HALT: instruction<=mem[0], instr_valid<=1, pc<=0, cnt<=HOLD_CYCLES-1, state<=RUN.
  - mem[0] == HALT: instruction<=IDLE_INSTR, pc<=0, state<=DONE.
  - start is ignored in RUN.
- RUN, each edge:
  - instr_valid<=0 unless a new instruction loads on that edge.
  - cnt!=0: cnt<=cnt-1; instruction holds.
  - cnt==0, pc == 2**ADDR_W-1: instruction<=IDLE_INSTR, state<=DONE; pc holds.
  - cnt==0, otherwise: fetch mem[pc+1].
    - Opcode 4'hF: instruction<=IDLE_INSTR, pc<=pc+1, state<=DONE.
    - Any other opcode: instruction<=mem[pc+1], pc<=pc+1, instr_valid<=1, cnt<=HOLD_CYCLES-1.
- Issue timing: each instruction is presented for exactly HOLD_CYCLES consecutive cycles. Slots are back-to-back, with no IDLE_INSTR gap between instructions.
- First-instruction latency: 1 cycle from the start edge, i.e. valid after the edge where start is sampled.
- stop=1 in RUN: next edge, instruction<=IDLE_INSTR, instr_valid<=0, state<=IDLE; pc holds its last value. stop takes priority over hold-expiry on the same edge. stop in IDLE or DONE has no effect.
- start and stop high together in IDLE or DONE: start wins.
- Unknown opcodes (2..E) are issued unmodified; decoding is the CPU's job.
- Async reset mid-RUN: outputs return to reset values immediately, with no clock needed.

Optional Feature:
- Macro SEQ_LOOP_EN.
- Defined: in RUN, a HALT fetch or end-of-memory wraps instead of terminating. pc<=0 and mem[0] is issued in the same timing as any other next instruction. DONE is never reached from RUN; only stop or reset ends execution. Exception: if mem[0] is HALT, start still goes directly to DONE.
- Not defined: termination behaviour exactly as in Behaviour.

Test Plan:
- Reset check: assert reset, then release → instruction=8'h00, instr_valid=0, pc=0, busy=0, done=0. Re-assert reset mid-RUN with no clock edge → outputs return to those values immediately.
- Basic run: write mem[0]=8'h01, mem[1]=8'h11, mem[2]=8'hF0; pulse start (HOLD_CYCLES=3) → 8'h01 for 3 cycles, then 8'h11 for 3 cycles, then 8'h00 with done=1, pc=2. instr_valid pulses exactly twice.
- Immediate HALT: mem[0]=8'hF0, pulse start → no instr_valid pulse; done=1 one cycle after start; instruction stays 8'h00.
- Abort: program of 4 ADDs (8'h01), stop asserted during the 2nd instruction's 2nd hold cycle → next cycle instruction=8'h00, busy=0, done=0, pc=1. A second start restarts from pc=0.
- Write lockout and end of memory: during RUN write mem[1]=8'h15 → ignored, 8'h11 is still issued. Fill all 16 entries with 8'h01 and run → 16 slots, then done=1 with pc=15.
- SEQ_LOOP_EN defined: mem[0]=8'h01, mem[1]=8'hF0 → 8'h01 re-issued every 3 cycles, done stays 0; stop returns to IDLE.

Source files
------------

// File: rtl/instr_sequencer.sv
// instr_sequencer: program store and timed instruction issuer for SimpleCPU.
// Define SEQ_LOOP_EN to wrap to address 0 on HALT/end-of-memory instead of stopping.
module instr_sequencer #(
  parameter int         ADDR_W      = 4,
  parameter int         HOLD_CYCLES = 3,
  parameter logic [7:0] IDLE_INSTR  = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [7:0]        prog_data,
  input  logic              start,
  input  logic              stop,
  output logic [7:0]        instruction,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR0    = '0;
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PC_LAST  = '1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t            state, state_n;
  logic [7:0]        mem [DEPTH];
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [7:0]        instr_n;
  logic              valid_n;
  logic [ADDR_W-1:0] pc_n;
  logic [ADDR_W-1:0] pc_inc;
  logic [7:0]        nxt;
  logic [7:0]        first;

  function automatic logic is_halt(input logic [7:0] i);
    return i[7:4] == 4'hF;
  endfunction

  assign pc_inc = pc + ADDR_ONE;
  assign nxt    = mem[pc_inc];
  assign first  = mem[ADDR0];
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  // Program store has no reset so a loaded program survives reset.
  always_ff @(posedge clk) begin
    if (prog_we && state != RUN)
      mem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      instruction <= IDLE_INSTR;
      instr_valid <= 1'b0;
      pc          <= '0;
      cnt         <= '0;
    end else begin
      state       <= state_n;
      instruction <= instr_n;
      instr_valid <= valid_n;
      pc          <= pc_n;
      cnt         <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    instr_n = instruction;
    valid_n = 1'b0;
    pc_n    = pc;
    cnt_n   = cnt;
    unique case (state)
      RUN: begin
        if (stop) begin
          instr_n = IDLE_INSTR;
          state_n = IDLE;
        end else if (cnt != '0) begin
          cnt_n = cnt - CNT_W'(1);
        end else if (pc == PC_LAST || is_halt(nxt)) begin
`ifdef SEQ_LOOP_EN
          pc_n    = '0;
          instr_n = first;
          valid_n = 1'b1;
          cnt_n   = CNT_LOAD;
`else
          instr_n = IDLE_INSTR;
          state_n = DONE;
          if (pc != PC_LAST)
            pc_n = pc_inc;
`endif
        end else begin
          instr_n = nxt;
          pc_n    = pc_inc;
          valid_n = 1'b1;
          cnt_n   = CNT_LOAD;
        end
      end
      default: begin
        if (start) begin
          pc_n = '0;
          if (is_halt(first)) begin
            instr_n = IDLE_INSTR;
            state_n = DONE;
          end else begin
            instr_n = first;
            valid_n = 1'b1;
            cnt_n   = CNT_LOAD;
            state_n = RUN;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed stimulus, timeline model and literal checks.
// Model expands the program into a per-cycle issue list when start is seen.
module tb_instr_sequencer;

  localparam int HOLD = 3;

  logic       clk = 0;
  logic       reset = 0;
  logic       prog_we = 0;
  logic [3:0] prog_addr = 0;
  logic [7:0] prog_data = 0;
  logic       start = 0;
  logic       stop = 0;
  logic [7:0] instruction;
  logic       instr_valid;
  logic [3:0] pc;
  logic       busy;
  logic       done;

  int vectors = 0;
  int miscompares = 0;

  instr_sequencer #(
    .ADDR_W(4),
    .HOLD_CYCLES(HOLD),
    .IDLE_INSTR(8'h00)
  ) dut (
    .clk(clk),
    .reset(reset),
    .prog_we(prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .start(start),
    .stop(stop),
    .instruction(instruction),
    .instr_valid(instr_valid),
    .pc(pc),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] i;
    logic       v;
    logic [3:0] p;
  } slot_t;

  logic [7:0] sm [16];
  slot_t      tl [$];
  int         m_st = 0;
  logic [7:0] m_i = 8'h00;
  logic       m_v = 0;
  logic [3:0] m_pc = 0;
  logic [3:0] term_pc = 0;

  function automatic void build();
    tl.delete();
    for (int a = 0; a < 16; a++) begin
      if (sm[a][7:4] == 4'hF) begin
        term_pc = a[3:0];
        return;
      end
      for (int h = 0; h < HOLD; h++)
        tl.push_back(slot_t'{sm[a], (h == 0), a[3:0]});
      term_pc = a[3:0];
    end
  endfunction

  function automatic void show();
    m_i  = tl[0].i;
    m_v  = tl[0].v;
    m_pc = tl[0].p;
  endfunction

  task automatic step();
    if (reset) begin
      m_st = 0; m_i = 8'h00; m_v = 0; m_pc = 0;
      tl.delete();
    end else if (m_st == 1) begin
      if (stop) begin
        tl.delete();
        m_st = 0; m_i = 8'h00; m_v = 0;
      end else begin
        void'(tl.pop_front());
`ifdef SEQ_LOOP_EN
        if (tl.size() == 0) build();
`endif
        if (tl.size() == 0) begin
          m_st = 2; m_i = 8'h00; m_v = 0; m_pc = term_pc;
        end else begin
          show();
        end
      end
    end else if (start) begin
      build();
      if (tl.size() == 0) begin
        m_st = 2; m_i = 8'h00; m_v = 0; m_pc = 0;
      end else begin
        m_st = 1;
        show();
      end
    end else if (prog_we) begin
      sm[prog_addr] = prog_data;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    step();
  end

  initial forever begin
    @(negedge clk);
    vectors++;
    if (instruction !== m_i || instr_valid !== m_v || pc !== m_pc ||
        busy !== (m_st == 1) || done !== (m_st == 2)) begin
      miscompares++;
      $display("FAIL model t=%0t: got i=%h v=%b pc=%0d busy=%b done=%b, want i=%h v=%b pc=%0d st=%0d",
               $time, instruction, instr_valid, pc, busy, done, m_i, m_v, m_pc, m_st);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    prog_we = 1; prog_addr = a; prog_data = d;
    @(negedge clk);
    prog_we = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic pulse_stop();
    @(negedge clk);
    stop = 1;
    @(negedge clk);
    stop = 0;
  endtask

  task automatic run_to_done(input int lim, output int pulses);
    int n = 0;
    pulses = instr_valid ? 1 : 0;
    while (!done && n < lim) begin
      @(negedge clk);
      n++;
      if (instr_valid) pulses++;
    end
    chk("done_reached", done, 1);
  endtask

  logic [7:0] bseq [6] = '{8'h01, 8'h01, 8'h01, 8'h11, 8'h11, 8'h11};
  int npulse;

  initial begin
    #1 reset = 1;
    repeat (2) @(negedge clk);
    chk("rst_instr", instruction, 8'h00);
    chk("rst_valid", instr_valid, 0);
    chk("rst_pc", pc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 0;
    @(negedge clk);
    chk("post_rst_instr", instruction, 8'h00);
    chk("post_rst_busy", busy, 0);

    wr(0, 8'h01); wr(1, 8'h11); wr(2, 8'hF0);
    pulse_start();
    npulse = 0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      chk("basic_instr", instruction, bseq[k]);
      if (instr_valid) npulse++;
    end
    chk("basic_first_valid_pulses", npulse, 2);
`ifndef SEQ_LOOP_EN
    @(negedge clk);
    chk("basic_end_instr", instruction, 8'h00);
    chk("basic_done", done, 1);
    chk("basic_pc", pc, 2);
    chk("basic_end_valid", instr_valid, 0);
`else
    pulse_stop();
`endif

    wr(0, 8'hF0);
    pulse_start();
    chk("halt0_done", done, 1);
    chk("halt0_instr", instruction, 8'h00);
    chk("halt0_valid", instr_valid, 0);
    chk("halt0_busy", busy, 0);

    for (int a = 0; a < 4; a++) wr(a[3:0], 8'h01);
    wr(4, 8'hF0);
    pulse_start();
    repeat (4) @(negedge clk);
    stop = 1;
    @(negedge clk);
    stop = 0;
    chk("abort_instr", instruction, 8'h00);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_pc", pc, 1);
    pulse_start();
    chk("restart_pc", pc, 0);
    chk("restart_instr", instruction, 8'h01);
    chk("restart_valid", instr_valid, 1);
    chk("restart_busy", busy, 1);
    #1 reset = 1;
    #1;
    chk("async_rst_instr", instruction, 8'h00);
    chk("async_rst_pc", pc, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_valid", instr_valid, 0);
    #1 reset = 0;

    wr(0, 8'h01); wr(1, 8'h11); wr(2, 8'hF0);
    pulse_start();
    wr(1, 8'h15);
    @(negedge clk);
    chk("lockout_instr", instruction, 8'h11);
    chk("lockout_pc", pc, 1);
`ifndef SEQ_LOOP_EN
    run_to_done(20, npulse);
    chk("lockout_end_pc", pc, 2);

    for (int a = 0; a < 16; a++) wr(a[3:0], 8'h01);
    pulse_start();
    run_to_done(100, npulse);
    chk("eom_pulses", npulse, 16);
    chk("eom_pc", pc, 15);
    chk("eom_instr", instruction, 8'h00);
`else
    pulse_stop();

    wr(0, 8'h01); wr(1, 8'hF0);
    pulse_start();
    npulse = instr_valid ? 1 : 0;
    for (int k = 1; k < 12; k++) begin
      @(negedge clk);
      if (instr_valid) npulse++;
      chk("loop_done", done, 0);
      chk("loop_instr", instruction, 8'h01);
    end
    chk("loop_pulses", npulse, 4);
    pulse_stop();
    chk("loop_stop_busy", busy, 0);
    chk("loop_stop_done", done, 0);
    chk("loop_stop_instr", instruction, 8'h00);
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
